// File: rtl/switch_debounce_pkg.sv
// Shared definitions for the switch debouncer.
//   NUM_SW_DEF     default number of switch channels
//   DB_CYCLES_DEF  default debounce hold time in clocks (10 ms at 100 MHz)
//   DB_CYCLES_SIM  short hold time used when simulating
//   db_state_e     per-channel debounce FSM state encoding
package switch_debounce_pkg;

  localparam int NUM_SW_DEF    = 3;
  localparam int DB_CYCLES_DEF = 1_000_000;
  localparam int DB_CYCLES_SIM = 4;

  typedef enum logic {
    STABLE_LOW  = 1'b0,
    STABLE_HIGH = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchronizer, hold counter, stable-level
// FSM and registered level/edge-pulse outputs.
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   raw    asynchronous switch input
//   level  debounced level (registered)
//   rise   one-cycle pulse on debounced 0->1 (registered)
//   fall   one-cycle pulse on debounced 1->0 (registered)
//
// state        | meaning
// -------------+------------------------------------------------
// STABLE_LOW   | debounced level is 0; counting synced 1 samples
// STABLE_HIGH  | debounced level is 1; counting synced 0 samples
module debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // Count value on the edge before the one that would reach DB_CYCLES.
  localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  db_state_e       state;
  db_state_e       state_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    // Any synced sample equal to the current level clears the count, so a
    // bounce restarts the hold time from zero.
    if (sync2 != logic'(state)) begin
      if (cnt == TERM) begin
        state_nxt = (state == STABLE_LOW) ? STABLE_HIGH : STABLE_LOW;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      state <= STABLE_LOW;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt   <= cnt_nxt;
      state <= state_nxt;
      // Outputs follow the FSM by one edge; level still holds the previous
      // state, which makes rise/fall a single-cycle pulse aligned with the
      // first cycle the new level is visible.
      level <= (state == STABLE_HIGH);
      rise  <= (state == STABLE_HIGH) && !level;
      fall  <= (state == STABLE_LOW) && level;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer; one independent debounce_chan per switch.
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   sw_raw    raw asynchronous switch inputs (bit 0 = S1, bit 1 = S2, ...)
//   sw_level  debounced stable level per channel
//   sw_rise   one-cycle pulse per debounced 0->1 transition
//   sw_fall   one-cycle pulse per debounced 1->0 transition
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int NUM_SW    = NUM_SW_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall
);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES(DB_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw_raw[i]),
      .level(sw_level[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;
  import switch_debounce_pkg::*;

  localparam int N  = 3;
  localparam int DB = DB_CYCLES_SIM;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_level;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;

  int errors = 0;
  int checks = 0;

  switch_debounce #(
    .NUM_SW   (N),
    .DB_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_raw  (sw_raw),
    .sw_level(sw_level),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #10 clk = ~clk;

  // Model: raw samples per edge (index 0 = this edge). The synchronizer
  // delays by two edges, so the debounced level flips once the DB most
  // recent synchronized samples (raw from DB+1 .. 2 edges ago) all differ
  // from it. Outputs show the model level one edge later.
  logic [N-1:0] hist [0:DB+1];
  logic [N-1:0] m_state = '0;
  logic [N-1:0] e_level = '0;
  logic [N-1:0] e_rise  = '0;
  logic [N-1:0] e_fall  = '0;

  task automatic model_tick();
    logic all_diff;
    if (rst) begin
      for (int i = 0; i <= DB + 1; i++) hist[i] = '0;
      m_state = '0;
      e_level = '0;
      e_rise  = '0;
      e_fall  = '0;
    end else begin
      e_rise  = m_state & ~e_level;
      e_fall  = ~m_state & e_level;
      e_level = m_state;
      for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sw_raw;
      for (int c = 0; c < N; c++) begin
        all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (hist[k][c] == m_state[c]) all_diff = 1'b0;
        if (all_diff) m_state[c] = ~m_state[c];
      end
    end
  endtask

  task automatic model_compare();
    checks++;
    if (sw_level !== e_level || sw_rise !== e_rise || sw_fall !== e_fall) begin
      errors++;
      $display("FAIL model t=%0t level=%b exp=%b rise=%b exp=%b fall=%b exp=%b",
               $time, sw_level, e_level, sw_rise, e_rise, sw_fall, e_fall);
    end
    checks++;
    if ((sw_rise & sw_fall) != '0) begin
      errors++;
      $display("FAIL rise_fall_overlap t=%0t rise=%b fall=%b exp_overlap=000",
               $time, sw_rise, sw_fall);
    end
  endtask

  // Advance n edges; model updates at each rising edge, DUT compared at the
  // following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_tick();
      @(negedge clk);
      model_compare();
    end
  endtask

  task automatic lit(input string name, input logic [N-1:0] lv,
                     input logic [N-1:0] rs, input logic [N-1:0] fl);
    checks++;
    if (sw_level !== lv || sw_rise !== rs || sw_fall !== fl) begin
      errors++;
      $display("FAIL %s t=%0t level=%b exp=%b rise=%b exp=%b fall=%b exp=%b",
               name, $time, sw_level, lv, sw_rise, rs, sw_fall, fl);
    end
  endtask

  initial begin
    rst    = 1'b1;
    sw_raw = '0;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step(1);
      lit("reset", 3'b000, 3'b000, 3'b000);
    end
    rst = 1'b0;
    step(2);

    // single press / release on S1
    sw_raw = 3'b001;
    step(6); lit("press_early",  3'b000, 3'b000, 3'b000);
    step(1); lit("press_pulse",  3'b001, 3'b001, 3'b000);
    step(1); lit("press_after",  3'b001, 3'b000, 3'b000);
    step(2);
    sw_raw = 3'b000;
    step(6); lit("release_early", 3'b001, 3'b000, 3'b000);
    step(1); lit("release_pulse", 3'b000, 3'b000, 3'b001);
    step(1); lit("release_after", 3'b000, 3'b000, 3'b000);
    step(2);

    // glitch on S2 shorter than the hold time
    sw_raw = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step(1); lit("glitch", 3'b000, 3'b000, 3'b000);
    end
    sw_raw = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step(1); lit("glitch", 3'b000, 3'b000, 3'b000);
    end

    // excursion of exactly the hold time is accepted
    sw_raw = 3'b010;
    step(4);
    sw_raw = 3'b000;
    step(2); lit("exact_early", 3'b000, 3'b000, 3'b000);
    step(1); lit("exact_pulse", 3'b010, 3'b010, 3'b000);
    step(12);

    // bounce on S3, then hold high
    sw_raw = 3'b100; step(1);
    sw_raw = 3'b000; step(1);
    sw_raw = 3'b100; step(1);
    sw_raw = 3'b000; step(1);
    sw_raw = 3'b100;
    step(6); lit("bounce_early", 3'b000, 3'b000, 3'b000);
    step(1); lit("bounce_pulse", 3'b100, 3'b100, 3'b000);
    step(1); lit("bounce_after", 3'b100, 3'b000, 3'b000);
    sw_raw = 3'b000;
    step(10);

    // all channels together
    sw_raw = 3'b111;
    step(6); lit("simul_early", 3'b000, 3'b000, 3'b000);
    step(1); lit("simul_pulse", 3'b111, 3'b111, 3'b000);
    step(1); lit("simul_after", 3'b111, 3'b000, 3'b000);
    step(2);
    sw_raw = 3'b000;
    step(6); lit("simul_rel_early", 3'b111, 3'b000, 3'b000);
    step(1); lit("simul_rel_pulse", 3'b000, 3'b000, 3'b111);
    step(3);

    // reset mid-count with S1 held high through release
    sw_raw = 3'b001;
    step(3); lit("midrst_pre", 3'b000, 3'b000, 3'b000);
    rst = 1'b1;
    step(1); lit("midrst_reset", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    step(6); lit("midrst_early", 3'b000, 3'b000, 3'b000);
    step(1); lit("midrst_pulse", 3'b001, 3'b001, 3'b000);
    step(1); lit("midrst_after", 3'b001, 3'b000, 3'b000);
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
